// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// digit width, blank pattern and the active-low hex glyph table.
package seg_scan_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low a..g, seg[6]=a .. seg[0]=g, indexed by hex value
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment glyph decoder.
module hex_to_seg7
   import seg_scan_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg_scan_driver.sv
// Common-anode multiplexed display driver: snapshots a count vector with a
// load/ack handshake and swaps it in only at frame boundaries.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int BLANK_LZ = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [DIGIT_W*DIGITS-1:0]  cnt_in,
   input  logic                       load,
   output logic                       ack,
   output logic                       frame,
   output logic [DIGITS-1:0]          an,
   output logic [6:0]                 seg
);

   localparam int VEC_W = DIGIT_W * DIGITS;
   localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]      pcnt;
   logic [IW-1:0]      idx;
   logic [VEC_W-1:0]   hold;
   logic [VEC_W-1:0]   disp;
   logic               pending;
   logic               fresh;

   logic               tick;
   logic               boundary;
   logic               frame_start;
   logic               blank;
   logic [IW-1:0]      top_nz;
   logic [DIGITS-1:0]  an_sel;
   logic [DIGIT_W-1:0] cur_digit;
   logic [6:0]         dec_seg;

   assign tick        = en && (pcnt == PW'(PRESCALE - 1));
   assign boundary    = tick && (idx == IW'(DIGITS - 1));
   assign frame_start = en && (idx == '0) && (pcnt == '0);
   assign cur_digit   = disp[int'(idx) * DIGIT_W +: DIGIT_W];

   // Highest non-zero digit; everything above it is a leading zero
   always_comb begin
      top_nz = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (disp[k*DIGIT_W +: DIGIT_W] != '0) top_nz = IW'(k);
      end
   end

   assign blank = (BLANK_LZ != 0) && (idx > top_nz);

   always_comb begin
      an_sel      = '1;
      an_sel[idx] = 1'b0;
   end

   hex_to_seg7 u_dec (
      .digit (cur_digit),
      .seg   (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt    <= '0;
         idx     <= '0;
         hold    <= '0;
         disp    <= '0;
         pending <= 1'b0;
         fresh   <= 1'b0;
         ack     <= 1'b0;
         frame   <= 1'b0;
         an      <= '1;
         seg     <= SEG_BLANK;
      end else begin
         if (tick) begin
            pcnt <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else if (en) begin
            pcnt <= pcnt + 1'b1;
         end

         // ack is deferred to the first digit-0 slot so it lines up with frame
         frame <= frame_start;
         ack   <= frame_start && fresh;
         if (frame_start) fresh <= 1'b0;

         if (boundary && load) begin
            hold    <= cnt_in;
            disp    <= cnt_in;
            pending <= 1'b0;
            fresh   <= 1'b1;
         end else if (boundary && pending) begin
            disp    <= hold;
            pending <= 1'b0;
            fresh   <= 1'b1;
         end else if (load) begin
            hold    <= cnt_in;
            pending <= 1'b1;
         end

         if (en && !blank) begin
            an  <= an_sel;
            seg <= dec_seg;
         end else begin
            an  <= '1;
            seg <= SEG_BLANK;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, prescale 4) with a
// cycle-position reference model and hand-computed spot checks.
module tb_seg_scan_driver;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;
   localparam int NSLOT    = DIGITS * PRESCALE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en;
   logic [15:0] cnt_in;
   logic        load;
   logic        ack;
   logic        frame;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int fails  = 0;
   int ack_cnt = 0;
   int ack_base;

   seg_scan_driver #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE),
      .BLANK_LZ (1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .cnt_in (cnt_in),
      .load   (load),
      .ack    (ack),
      .frame  (frame),
      .an     (an),
      .seg    (seg)
   );

   always #5 clk = ~clk;

   logic [6:0] segtab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   logic [3:0] an_lit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg1234  [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

   // Reference model: one position counter over the whole frame
   int          pos, dig, m;
   logic [15:0] mval, mhold;
   bit          mpend, mfresh;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_ack, exp_frame;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pos = 0; mval = '0; mhold = '0; mpend = 0; mfresh = 0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_ack = 1'b0; exp_frame = 1'b0;
      end else begin
         dig = pos / PRESCALE;
         m = 0;
         for (int k = 0; k < DIGITS; k++) if (mval[4*k +: 4] != 4'h0) m = k;
         if (en && dig <= m) begin
            exp_an  = ~(4'b0001 << dig);
            exp_seg = segtab[mval[4*dig +: 4]];
         end else begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
         end
         exp_frame = en && (pos == 0);
         exp_ack   = exp_frame && mfresh;
         if (exp_frame) mfresh = 0;
         if (en && pos == NSLOT - 1) begin
            if (load) mval = cnt_in;
            else if (mpend) mval = mhold;
            if (load || mpend) mfresh = 1;
            mpend = 0;
         end else if (load) begin
            mhold = cnt_in;
            mpend = 1;
         end
         if (en) pos = (pos + 1) % NSLOT;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || ack !== exp_ack || frame !== exp_frame) begin
         fails++;
         $display("FAIL model t=%0t an=%b/%b seg=%b/%b ack=%b/%b frame=%b/%b (got/required)",
                  $time, an, exp_an, seg, exp_seg, ack, exp_ack, frame, exp_frame);
      end
   end

   always @(negedge clk) if (ack === 1'b1) ack_cnt++;

   function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ack();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack !== 1'b1 && n < 3 * NSLOT);
      chk("ack_seen", {15'd0, ack}, 16'd1);
      if (ack === 1'b1) chk("ack_with_frame", {15'd0, frame}, 16'd1);
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      cnt_in = v;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      en = 1'b1; load = 1'b0; cnt_in = '0;

      // Reset state, then first cycle after release
      step(3);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_ack", ack, 0);
      chk("rst_frame", frame, 0);
      rst = 1'b0;
      step(1);
      chk("rel_an", an, 4'b1110);
      chk("rel_seg", seg, 7'b0000001);
      chk("rel_frame", frame, 1);

      // Pending snapshot then asynchronous reset at idx=2
      do_load(16'h9999);
      step(7);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_an", an, 4'hF);
      chk("async_rst_seg", seg, 7'h7F);
      step(2);
      rst = 1'b0;
      step(1);
      chk("rel2_an", an, 4'b1110);
      chk("rel2_seg", seg, 7'b0000001);
      chk("rel2_frame", frame, 1);
      ack_base = ack_cnt;
      step(40);
      chk("no_ack_after_rst", 16'(ack_cnt), 16'(ack_base));

      // 0x1234 full scan
      do_load(16'h1234);
      wait_ack();
      for (int i = 0; i < 16; i++) begin
         chk("scan1234_an", an, an_lit[i/4]);
         chk("scan1234_seg", seg, seg1234[i/4]);
         step(1);
      end
      chk("frame_ref", frame, 1);

      // 0x00A5 loaded mid-frame
      ack_base = ack_cnt;
      do_load(16'h00A5);
      step(11);
      chk("old_hold_an", an, 4'b0111);
      chk("old_hold_seg", seg, 7'b1001111);
      wait_ack();
      chk("a5_d0_an", an, 4'b1110);
      chk("a5_d0_seg", seg, 7'b0100100);
      step(4);
      chk("a5_d1_an", an, 4'b1101);
      chk("a5_d1_seg", seg, 7'b0001000);
      step(4);
      chk("a5_d2_blank_an", an, 4'hF);
      chk("a5_d2_blank_seg", seg, 7'h7F);
      step(4);
      chk("a5_d3_blank_an", an, 4'hF);
      step(4);
      chk("a5_single_ack", 16'(ack_cnt), 16'(ack_base + 1));

      // Two loads in one frame: latest wins, one ack
      ack_base = ack_cnt;
      do_load(16'h1111);
      step(2);
      do_load(16'h2222);
      wait_ack();
      chk("latest_d0_seg", seg, 7'b0010010);
      step(12);
      chk("latest_d3_an", an, 4'b0111);
      chk("latest_d3_seg", seg, 7'b0010010);
      step(4);
      chk("latest_single_ack", 16'(ack_cnt), 16'(ack_base + 1));

      // Load coincident with the boundary
      chk("bnd_ref_frame", frame, 1);
      step(14);
      load = 1'b1; cnt_in = 16'h0007;
      step(1);
      load = 1'b0;
      chk("bnd_no_early_ack", ack, 0);
      step(1);
      chk("bnd_ack", ack, 1);
      chk("bnd_frame", frame, 1);
      chk("bnd_an", an, 4'b1110);
      chk("bnd_seg", seg, 7'b0001111);

      // Enable dropped for 10 cycles at idx=1, pcnt=2
      do_load(16'h1234);
      wait_ack();
      step(5);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("en_low_an", an, 4'hF);
      end
      en = 1'b1;
      step(1);
      chk("resume_d1_a", an, 4'b1101);
      step(1);
      chk("resume_d1_b", an, 4'b1101);
      step(1);
      chk("resume_d2", an, 4'b1011);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 7-segment display driver that consumes the 4-bit count values produced by the synchronous counter stages and shows them on a common-anode LED display. It snapshots a multi-digit count vector via a load/ack handshake and applies the update only at a frame boundary, so the display never shows a mixed frame. It scans one digit per prescaler period, decodes full hex, and blanks leading zeros. It sits directly downstream of the cascaded counter chain.

## Interface
- DIGITS, 4: number of digits scanned (1–8).
- PRESCALE, 1000: clk cycles per digit slot (≥2).
- BLANK_LZ, 1: 1 = blank leading zero digits. Digit 0 is never blanked.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable. Low: prescaler and index frozen, display dark.
- cnt_in  in  4*DIGITS  count vector. Digit k is cnt_in[4k+3:4k], and bit 4k+3 is the digit's MSB.
- load  in  1  single-cycle snapshot request; cnt_in is sampled on the same edge.
- ack  out  1  one-cycle pulse: the snapshot has been transferred to the display register.
- frame  out  1  one-cycle pulse at the start of each scan frame (digit 0 slot).
- an  out  DIGITS  digit enables, active-low, at most one low.
- seg  out  7  segments, active-low. seg[6]=a through seg[0]=g.

## Operation
- State:
  - prescaler `pcnt` counts 0..PRESCALE-1.
  - scan index `idx` counts 0..DIGITS-1.
  - `hold` register (4*DIGITS bits).
  - `pending` flag.
  - `disp` register (4*DIGITS bits).
- tick = en && pcnt==PRESCALE-1. On tick, pcnt goes to 0 and idx increments, wrapping from DIGITS-1 to 0. Otherwise, when en is high, pcnt increments.
- Boundary = tick && idx==DIGITS-1.
- load: hold <= cnt_in and pending <= 1. A second load before the boundary overwrites hold (latest wins, single ack).
- At a boundary with pending=1: disp <= hold, pending <= 0, ack=1 on the next cycle.
- load coincident with a boundary: disp <= cnt_in directly, pending stays 0, ack next cycle.
- Leading-zero blanking: let m be the highest digit index with disp digit ≠ 0 (m=0 if all digits are zero). Slots with idx > m drive an all-high and seg=7'h7F.
- Hex decode, active-low a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- en low: an all-high and seg=7'h7F from the next cycle. pending and load handling still operate, but no boundary occurs while en is low. When en returns high, scanning resumes from the frozen idx/pcnt.

## Timing
- an, seg, ack and frame are registered. an and seg reflect idx and disp with 1-cycle latency.
- Reset (asynchronous, immediate):
  - pcnt=0, idx=0, hold=0, disp=0, pending=0.
  - ack=0, frame=0, an=all-high, seg=7'h7F.
- First cycle after reset release (en=1): an=...1110, seg=0000001 ("0"), frame=1.
- frame pulses in the cycle in which an first selects digit 0 of each frame.
- Load-to-display latency is at most DIGITS*PRESCALE+1 cycles. ack is aligned with the frame pulse of the first frame that shows the new value.
- Reset asserted mid-frame or with a load pending: the pending snapshot is discarded and no ack is issued.

## Structure
- Package seg_scan_pkg holds:
  - the SEG_BLANK constant (7'h7F);
  - the 16-entry hex-to-segment constant table;
  - the digit-width localparam (4).
- One sub-module, hex_to_seg7: combinational 4-bit to 7-segment decoder using the package table. It is instantiated once on the muxed digit.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4, BLANK_LZ=1.
- Reset mid-scan (idx=2): an=1111 and seg=7F immediately. After release, an=1110, seg=0000001, frame=1.
- Load 0x1234, wait for ack. Then an cycles 1110/1101/1011/0111, 4 cycles each, with seg 1001100/0000110/0010010/1001111.
- Load 0x00A5 mid-frame: the old value holds until the boundary, and ack pulses once. Then digit0=0100100, digit1=0001000, and the slots for digits 2 and 3 show an=1111.
- Load 0x1111 then 0x2222 in the same frame: exactly one ack, and only 0x2222 is displayed.
- Load 0x0007 on the boundary cycle: the next frame shows 0001111 on digit 0, with ack in the same cycle as frame.
- Drop en for 10 cycles at idx=1, pcnt=2: an=1111 throughout. On re-enable, digit 1 remains selected for the 2 remaining cycles of its slot.
